// File: rtl/hpram_arb_pkg.sv
// Shared types for the HyperRAM command arbiter: FSM states, command codes
// and requester grant identifiers.
package hpram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_GAP      = 2'd3
    } state_e;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/hpram_cmd_arbiter_if.sv
// Requester and memory-side signal bundle of the HyperRAM command arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface hpram_cmd_arbiter_if #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    // camera write requester
    logic              iwr_req;
    logic [ADDR_W-1:0] iwr_addr;
    logic              owr_ack;
    logic              owr_data_req;
    logic [DATA_W-1:0] iwr_data;
    logic [MASK_W-1:0] iwr_mask;
    logic              owr_done;

    // display read requester
    logic              ird_req;
    logic [ADDR_W-1:0] ird_addr;
    logic              ord_ack;
    logic              ord_valid;
    logic [DATA_W-1:0] ord_data;
    logic              ord_done;

    // memory controller command port
    logic              ocmd;
    logic              ocmd_en;
    logic [ADDR_W-1:0] oaddr;
    logic [DATA_W-1:0] owr_data;
    logic [MASK_W-1:0] odata_mask;
    logic              imem_rd_valid;
    logic [DATA_W-1:0] imem_rd_data;

    modport slave (
        input  iwr_req, iwr_addr, iwr_data, iwr_mask,
        input  ird_req, ird_addr,
        input  imem_rd_valid, imem_rd_data,
        output owr_ack, owr_data_req, owr_done,
        output ord_ack, ord_valid, ord_data, ord_done,
        output ocmd, ocmd_en, oaddr, owr_data, odata_mask
    );

    modport master (
        output iwr_req, iwr_addr, iwr_data, iwr_mask,
        output ird_req, ird_addr,
        output imem_rd_valid, imem_rd_data,
        input  owr_ack, owr_data_req, owr_done,
        input  ord_ack, ord_valid, ord_data, ord_done,
        input  ocmd, ocmd_en, oaddr, owr_data, odata_mask
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester not granted last
// wins; the history register only moves when a grant is actually issued.
module rr_arb2
    import hpram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr_c,
    output logic gnt_rd_c
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    always_comb begin
        gnt_wr_c     = 1'b0;
        gnt_rd_c     = 1'b0;
        last_grant_d = last_grant_q;
        if (en) begin
            if (req_wr && req_rd) begin
                if (last_grant_q == GNT_WR) gnt_rd_c = 1'b1;
                else                        gnt_wr_c = 1'b1;
            end else if (req_rd) begin
                gnt_rd_c = 1'b1;
            end else if (req_wr) begin
                gnt_wr_c = 1'b1;
            end
        end
        if (gnt_rd_c)      last_grant_d = GNT_RD;
        else if (gnt_wr_c) last_grant_d = GNT_WR;
    end

    // Reset history to WRITE so the read side wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= GNT_WR;
        else     last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/hpram_cmd_arbiter.sv
// Shares the HyperRAM command port between the camera write DMA and the
// display read DMA: grant, command issue, beat pacing, spacing and timeout.
module hpram_cmd_arbiter
    import hpram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WR_BEATS   = 16,
    parameter int unsigned RD_BEATS   = 16,
    parameter int unsigned CMD_GAP    = 4,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               iinit_calib,
    hpram_cmd_arbiter_if.slave bus,
    output logic               obusy,
    output logic               oerr_timeout
);

    localparam int unsigned MASK_W   = DATA_W / 8;
    localparam int unsigned BEAT_MAX = (WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS;
    localparam int unsigned BEAT_W   = $clog2(BEAT_MAX + 1);
    localparam int unsigned TMR_W    = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned GAP_W    = $clog2(CMD_GAP + 1);

    state_e              state_q,      state_d;
    logic [BEAT_W-1:0]   beat_q,       beat_d;
    logic [TMR_W-1:0]    tmr_q,        tmr_d;
    logic [GAP_W-1:0]    gap_q,        gap_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;

    logic                wr_ack_q,     wr_ack_d;
    logic                wr_data_req_q, wr_data_req_d;
    logic                wr_done_q,    wr_done_d;
    logic                rd_ack_q,     rd_ack_d;
    logic                rd_valid_q,   rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q,    rd_data_d;
    logic                rd_done_q,    rd_done_d;
    logic                cmd_q,        cmd_d;
    logic                cmd_en_q,     cmd_en_d;
    logic [ADDR_W-1:0]   oaddr_q,      oaddr_d;
    logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
    logic [MASK_W-1:0]   mask_q,       mask_d;
    logic                busy_q,       busy_d;
    logic                err_q,        err_d;

    logic                gnt_wr_c;
    logic                gnt_rd_c;

    rr_arb2 u_rr_arb2 (
        .clk      (iclk),
        .rst      (irst),
        .en       ((state_q == ST_IDLE) && iinit_calib),
        .req_wr   (bus.iwr_req),
        .req_rd   (bus.ird_req),
        .gnt_wr_c (gnt_wr_c),
        .gnt_rd_c (gnt_rd_c)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        tmr_d         = tmr_q;
        gap_d         = gap_q;
        addr_d        = addr_q;
        err_d         = err_q;
        wr_ack_d      = 1'b0;
        wr_data_req_d = 1'b0;
        wr_done_d     = 1'b0;
        rd_ack_d      = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = '0;
        rd_done_d     = 1'b0;
        cmd_d         = CMD_WR;
        cmd_en_d      = 1'b0;
        oaddr_d       = '0;
        wr_data_d     = '0;
        mask_d        = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_rd_c) begin
                    rd_ack_d = 1'b1;
                    addr_d   = bus.ird_addr;
                    beat_d   = '0;
                    tmr_d    = '0;
                    state_d  = ST_RD_WAIT;
                end else if (gnt_wr_c) begin
                    wr_ack_d      = 1'b1;
                    wr_data_req_d = 1'b1;
                    addr_d        = bus.iwr_addr;
                    beat_d        = '0;
                    state_d       = ST_WR_BURST;
                end
            end

            // One beat is popped per cycle starting on the grant cycle; the
            // command goes out alongside the first registered beat.
            ST_WR_BURST: begin
                wr_data_d = bus.iwr_data;
                mask_d    = bus.iwr_mask;
                if (beat_q == '0) begin
                    cmd_en_d = 1'b1;
                    cmd_d    = CMD_WR;
                    oaddr_d  = addr_q;
                end
                if (beat_q == BEAT_W'(WR_BEATS - 1)) begin
                    wr_done_d = 1'b1;
                    gap_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    wr_data_req_d = 1'b1;
                    beat_d        = beat_q + BEAT_W'(1);
                end
            end

            // tmr_q is 0 on the grant cycle, so a timeout decided at
            // RD_TIMEOUT lands RD_TIMEOUT cycles after the command strobe.
            ST_RD_WAIT: begin
                if (tmr_q == '0) begin
                    cmd_en_d = 1'b1;
                    cmd_d    = CMD_RD;
                    oaddr_d  = addr_q;
                end
                if (bus.imem_rd_valid && (beat_q == BEAT_W'(RD_BEATS - 1))) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = bus.imem_rd_data;
                    rd_done_d  = 1'b1;
                    gap_d      = '0;
                    state_d    = ST_GAP;
                end else if (tmr_q == TMR_W'(RD_TIMEOUT)) begin
                    rd_done_d = 1'b1;
                    err_d     = 1'b1;
                    gap_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                    if (bus.imem_rd_valid) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.imem_rd_data;
                        beat_d     = beat_q + BEAT_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_W'(CMD_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            tmr_q         <= '0;
            gap_q         <= '0;
            addr_q        <= '0;
            wr_ack_q      <= 1'b0;
            wr_data_req_q <= 1'b0;
            wr_done_q     <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_done_q     <= 1'b0;
            cmd_q         <= 1'b0;
            cmd_en_q      <= 1'b0;
            oaddr_q       <= '0;
            wr_data_q     <= '0;
            mask_q        <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            tmr_q         <= tmr_d;
            gap_q         <= gap_d;
            addr_q        <= addr_d;
            wr_ack_q      <= wr_ack_d;
            wr_data_req_q <= wr_data_req_d;
            wr_done_q     <= wr_done_d;
            rd_ack_q      <= rd_ack_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_done_q     <= rd_done_d;
            cmd_q         <= cmd_d;
            cmd_en_q      <= cmd_en_d;
            oaddr_q       <= oaddr_d;
            wr_data_q     <= wr_data_d;
            mask_q        <= mask_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign bus.owr_ack      = wr_ack_q;
    assign bus.owr_data_req = wr_data_req_q;
    assign bus.owr_done     = wr_done_q;
    assign bus.ord_ack      = rd_ack_q;
    assign bus.ord_valid    = rd_valid_q;
    assign bus.ord_data     = rd_data_q;
    assign bus.ord_done     = rd_done_q;
    assign bus.ocmd         = cmd_q;
    assign bus.ocmd_en      = cmd_en_q;
    assign bus.oaddr        = oaddr_q;
    assign bus.owr_data     = wr_data_q;
    assign bus.odata_mask   = mask_q;
    assign obusy            = busy_q;
    assign oerr_timeout     = err_q;

endmodule

// File: tb/tb_hpram_cmd_arbiter.sv
// Directed-sequence bench for hpram_cmd_arbiter with randomized data,
// addresses and memory return timing, checked against per-transaction timing rules.
module tb_hpram_cmd_arbiter;
    import hpram_arb_pkg::*;

    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MASK_W     = DATA_W / 8;
    localparam int unsigned WR_BEATS   = 16;
    localparam int unsigned RD_BEATS   = 16;
    localparam int unsigned CMD_GAP    = 4;
    localparam int unsigned RD_TIMEOUT = 255;

    logic iclk = 1'b0;
    logic irst;
    logic iinit_calib;
    logic obusy;
    logic oerr_timeout;

    hpram_cmd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    hpram_cmd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_BEATS(WR_BEATS),
        .RD_BEATS(RD_BEATS), .CMD_GAP(CMD_GAP), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .iinit_calib  (iinit_calib),
        .bus          (bus),
        .obusy        (obusy),
        .oerr_timeout (oerr_timeout)
    );

    always #5 iclk = ~iclk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] wbeat [WR_BEATS];
    logic [MASK_W-1:0] wmask [WR_BEATS];
    int unsigned       bcyc  [$];
    logic [DATA_W-1:0] rbeat [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({bus.owr_ack, bus.ord_ack, bus.owr_data_req, bus.owr_done,
                      bus.ord_valid, bus.ord_done, bus.ocmd, bus.ocmd_en,
                      obusy, oerr_timeout}), 64'(0));
        chk({tag, "_wdata"}, 64'(bus.owr_data), 64'(0));
        chk({tag, "_mask"},  64'(bus.odata_mask), 64'(0));
        chk({tag, "_addr"},  64'(bus.oaddr), 64'(0));
        chk({tag, "_rdata"}, 64'(bus.ord_data), 64'(0));
    endtask

    function automatic void fill_wbeats(input bit rnd);
        for (int k = 0; k < int'(WR_BEATS); k++) begin
            wbeat[k] = rnd ? DATA_W'($urandom) : DATA_W'(k);
            wmask[k] = rnd ? MASK_W'($urandom) : '1;
        end
    endfunction

    // Entered on the grant cycle T0 (t=0); returns on the first idle cycle.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input bit hold_req, input bit err_in);
        int widx = 0;
        if (!hold_req) bus.iwr_req = 1'b0;
        for (int t = 0; t <= int'(WR_BEATS + CMD_GAP); t++) begin
            bus.iwr_data = (widx < int'(WR_BEATS)) ? wbeat[widx] : DATA_W'($urandom);
            bus.iwr_mask = (widx < int'(WR_BEATS)) ? wmask[widx] : MASK_W'($urandom);
            chk1("wr_data_req", bus.owr_data_req, t < int'(WR_BEATS));
            chk1("wr_cmd_en", bus.ocmd_en, t == 1);
            if (t == 1) begin
                chk1("wr_cmd", bus.ocmd, CMD_WR);
                chk("wr_addr", 64'(bus.oaddr), 64'(addr));
            end
            if (t >= 1 && t <= int'(WR_BEATS)) begin
                chk("wr_beat", 64'(bus.owr_data), 64'(wbeat[t-1]));
                chk("wr_mask", 64'(bus.odata_mask), 64'(wmask[t-1]));
            end
            chk1("wr_done", bus.owr_done, t == int'(WR_BEATS));
            chk1("wr_busy", obusy, t < int'(WR_BEATS + CMD_GAP));
            chk1("wr_err", oerr_timeout, err_in);
            chk1("wr_no_rd_beat", bus.ord_valid | bus.ord_done, 1'b0);
            if (t > 0) chk("wr_ack_idle", 64'({bus.owr_ack, bus.ord_ack}), 64'(0));
            if (bus.owr_data_req && widx < int'(WR_BEATS)) widx++;
            if (t < int'(WR_BEATS + CMD_GAP)) tick();
        end
    endtask

    // Memory returns n beats; bubble<0 picks 0..3 idle cycles between beats.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input int n, input int bubble,
                           input bit hold_req, input bit err_in);
        int unsigned       c;
        int unsigned       d_cyc;
        int                bi;
        bit                tmo;
        bit                drove;
        bit                exp_v;
        logic [DATA_W-1:0] exp_d;
        bcyc.delete();
        rbeat.delete();
        c = 2 + $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            bcyc.push_back(c);
            rbeat.push_back(DATA_W'($urandom));
            c += 1 + ((bubble < 0) ? $urandom_range(0, 3) : int'(bubble));
        end
        tmo   = (n < int'(RD_BEATS));
        d_cyc = tmo ? RD_TIMEOUT + 1 : bcyc[n-1] + 1;
        if (tmo) begin
            for (int i = 1; i <= 3; i++) begin
                bcyc.push_back(d_cyc + i);
                rbeat.push_back(DATA_W'($urandom));
            end
        end
        bi    = 0;
        exp_v = 1'b0;
        exp_d = '0;
        if (!hold_req) bus.ird_req = 1'b0;
        for (int unsigned t = 0; t <= d_cyc + CMD_GAP; t++) begin
            drove = (bi < bcyc.size()) && (bcyc[bi] == t);
            bus.imem_rd_valid = drove;
            bus.imem_rd_data  = drove ? rbeat[bi] : DATA_W'($urandom);
            chk1("rd_valid", bus.ord_valid, exp_v);
            if (exp_v) chk("rd_data", 64'(bus.ord_data), 64'(exp_d));
            chk1("rd_done", bus.ord_done, t == d_cyc);
            chk1("rd_cmd_en", bus.ocmd_en, t == 1);
            if (t == 1) begin
                chk1("rd_cmd", bus.ocmd, CMD_RD);
                chk("rd_addr", 64'(bus.oaddr), 64'(addr));
            end
            chk1("rd_busy", obusy, t < d_cyc + CMD_GAP);
            chk1("rd_err", oerr_timeout, err_in || (tmo && t >= d_cyc));
            chk1("rd_no_wr_beat", bus.owr_data_req | bus.owr_done, 1'b0);
            if (t > 0) chk("rd_ack_idle", 64'({bus.owr_ack, bus.ord_ack}), 64'(0));
            exp_v = drove && (t + 1 <= d_cyc);
            if (drove) begin
                exp_d = rbeat[bi];
                bi++;
            end
            if (t < d_cyc + CMD_GAP) tick();
        end
        bus.imem_rd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack;
        int ncmd;
        int widx;
        logic [ADDR_W-1:0] a;

        irst              = 1'b1;
        iinit_calib       = 1'b0;
        bus.iwr_req       = 1'b0;
        bus.iwr_addr      = '0;
        bus.iwr_data      = '0;
        bus.iwr_mask      = '0;
        bus.ird_req       = 1'b0;
        bus.ird_addr      = '0;
        bus.imem_rd_valid = 1'b0;
        bus.imem_rd_data  = '0;

        // reset state
        repeat (3) tick();
        chk_all_zero("reset");
        irst = 1'b0;

        // no grants before calibration
        bus.iwr_req  = 1'b1;
        bus.ird_req  = 1'b1;
        bus.iwr_addr = ADDR_W'($urandom);
        bus.ird_addr = ADDR_W'($urandom);
        nack = 0;
        ncmd = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.owr_ack || bus.ord_ack) nack++;
            if (bus.ocmd_en || obusy) ncmd++;
        end
        chk("precalib_ack", 64'(nack), 64'(0));
        chk("precalib_cmd", 64'(ncmd), 64'(0));

        // calibration done: read wins the first tie, then strict alternation
        iinit_calib = 1'b1;
        tick();
        chk1("first_rd_ack", bus.ord_ack, 1'b1);
        chk1("first_wr_ack", bus.owr_ack, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                do_read(bus.ird_addr, int'(RD_BEATS), -1, 1'b1, 1'b0);
            end else begin
                fill_wbeats(1'b1);
                do_write(bus.iwr_addr, 1'b1, 1'b0);
            end
            if (k == 3) begin
                bus.iwr_req = 1'b0;
                bus.ird_req = 1'b0;
            end
            tick();
            if (k < 3) begin
                chk1("alt_wr_ack", bus.owr_ack, k % 2 == 0);
                chk1("alt_rd_ack", bus.ord_ack, k % 2 == 1);
            end else begin
                chk("alt_end_no_ack", 64'({bus.owr_ack, bus.ord_ack}), 64'(0));
            end
        end

        // single write, counting data
        bus.iwr_addr = ADDR_W'(22'h00100);
        fill_wbeats(1'b0);
        bus.iwr_req = 1'b1;
        tick();
        chk1("single_wr_ack", bus.owr_ack, 1'b1);
        do_write(ADDR_W'(22'h00100), 1'b0, 1'b0);

        // single read with 2-cycle bubbles
        bus.ird_addr = ADDR_W'(22'h2A000);
        bus.ird_req  = 1'b1;
        tick();
        chk1("single_rd_ack", bus.ord_ack, 1'b1);
        do_read(ADDR_W'(22'h2A000), int'(RD_BEATS), 2, 1'b0, 1'b0);

        // short read times out; late beats are dropped
        a = ADDR_W'($urandom);
        bus.ird_addr = a;
        bus.ird_req  = 1'b1;
        tick();
        chk1("tmo_rd_ack", bus.ord_ack, 1'b1);
        do_read(a, 5, -1, 1'b0, 1'b0);

        // a write afterwards is unaffected; error stays sticky
        a = ADDR_W'($urandom);
        bus.iwr_addr = a;
        fill_wbeats(1'b1);
        bus.iwr_req = 1'b1;
        tick();
        chk1("post_tmo_wr_ack", bus.owr_ack, 1'b1);
        do_write(a, 1'b0, 1'b1);

        // calibration lost mid-write: the write completes, nothing new starts
        a = ADDR_W'($urandom);
        bus.iwr_addr = a;
        fill_wbeats(1'b1);
        bus.iwr_req = 1'b1;
        tick();
        chk1("calib_drop_wr_ack", bus.owr_ack, 1'b1);
        iinit_calib  = 1'b0;
        bus.ird_req  = 1'b1;
        bus.ird_addr = ADDR_W'($urandom);
        do_write(a, 1'b0, 1'b1);
        nack = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.owr_ack || bus.ord_ack) nack++;
        end
        chk("calib_low_no_ack", 64'(nack), 64'(0));
        iinit_calib = 1'b1;
        tick();
        chk1("calib_back_rd_ack", bus.ord_ack, 1'b1);
        do_read(bus.ird_addr, int'(RD_BEATS), -1, 1'b0, 1'b1);

        // reset in the middle of a write with a read pending
        a = ADDR_W'($urandom);
        bus.iwr_addr = a;
        fill_wbeats(1'b1);
        bus.iwr_req = 1'b1;
        tick();
        chk1("rst_wr_ack", bus.owr_ack, 1'b1);
        bus.iwr_req  = 1'b0;
        bus.ird_req  = 1'b1;
        bus.ird_addr = ADDR_W'($urandom);
        widx = 0;
        for (int t = 0; t <= 8; t++) begin
            bus.iwr_data = wbeat[widx];
            bus.iwr_mask = wmask[widx];
            if (t == 8) chk("rst_beat7", 64'(bus.owr_data), 64'(wbeat[7]));
            if (bus.owr_data_req) widx++;
            if (t < 8) tick();
        end
        irst = 1'b1;
        tick();
        chk_all_zero("mid_rst");
        irst = 1'b0;
        tick();
        chk1("post_rst_rd_ack", bus.ord_ack, 1'b1);
        chk1("post_rst_wr_ack", bus.owr_ack, 1'b0);
        do_read(bus.ird_addr, int'(RD_BEATS), -1, 1'b0, 1'b0);
        chk1("final_idle", obusy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpram_cmd_arbiter.md
Name: hpram_cmd_arbiter

Overview:
Shares the single HyperRAM memory-interface command port between two DMA requesters: camera write and HDMI display read. It runs in the dma_clk domain, between the frame-buffer DMA engines and the HyperRAM controller. It owns the command sequencing: grant, command issue, write-beat pacing, read-beat collection, command spacing and read timeout. Nothing is issued until memory calibration completes.

Parameters:
ADDR_W, 22, memory word-address width
DATA_W, 32, data beat width (mask width = DATA_W/8)
WR_BEATS, 16, beats per write burst (≥2)
RD_BEATS, 16, beats per read burst (≥1)
CMD_GAP, 4, idle cycles enforced after every transaction (≥1)
RD_TIMEOUT, 255, max cycles from read cmd_en to last beat

Ports:
iclk  in  1  dma_clk; the only clock
irst  in  1  synchronous reset, active-high
iinit_calib  in  1  memory calibration done
iwr_req  in  1  write request, level, held until owr_ack
iwr_addr  in  ADDR_W  write burst start address
owr_ack  out  1  one-cycle grant pulse
owr_data_req  out  1  requester must present next beat this same cycle (FWFT pop)
iwr_data  in  DATA_W  write beat
iwr_mask  in  DATA_W/8  write byte mask
owr_done  out  1  pulse on the cycle of the last write beat at the memory
ird_req  in  1  read request, level, held until ord_ack
ird_addr  in  ADDR_W  read burst start address
ord_ack  out  1  one-cycle grant pulse
ord_valid  out  1  read beat valid
ord_data  out  DATA_W  read beat
ord_done  out  1  pulse with the last beat, or on timeout
ocmd  out  1  0=write, 1=read
ocmd_en  out  1  command strobe
oaddr  out  ADDR_W  command address
owr_data  out  DATA_W  write beat to memory
odata_mask  out  DATA_W/8  write mask to memory
imem_rd_valid  in  1  read beat valid from memory
imem_rd_data  in  DATA_W  read beat from memory
obusy  out  1  state ≠ IDLE
oerr_timeout  out  1  sticky read-timeout flag; cleared only by irst

Behaviour:
- Reset: all outputs 0, state IDLE, gap counter 0, last_grant=WRITE (read wins the first tie).
- States: IDLE, WR_BURST, RD_WAIT, GAP.
- IDLE: grant only if iinit_calib=1. One requester → grant it. Both → round-robin against last_grant. Grant cycle T0: the ack pulses, the address is latched, last_grant is updated.
- Write: owr_data_req=1 for T0..T0+WR_BEATS-1; beat k is registered and appears on owr_data/odata_mask at T1+k. ocmd_en=1, ocmd=0 and oaddr valid only at T1. owr_done pulses at T0+WR_BEATS. Then GAP.
- Read: ocmd_en=1, ocmd=1 at T1. RD_WAIT counts imem_rd_valid beats. Each beat is forwarded registered, one cycle later, on ord_valid/ord_data. ord_done accompanies beat RD_BEATS. Then GAP.
- Timeout: counter starts at T1. If RD_TIMEOUT expires before the last beat: ord_done pulses with ord_valid=0, oerr_timeout is set, state goes to GAP. Late beats are ignored.
- imem_rd_valid outside RD_WAIT is ignored.
- GAP: exactly CMD_GAP cycles, then IDLE. Minimum grant-to-grant spacing is WR_BEATS+1+CMD_GAP (write) or read completion +1+CMD_GAP.
- Requests arriving during non-IDLE states wait; requests are never dropped.
- iinit_calib falling mid-transaction: the transaction completes; no new grants.
- irst mid-transaction: immediate return to reset state. No done pulse; the requester is responsible for discarding partial bursts.
- Beat and timer counters: width clog2(max+1); no wrap possible within one transaction.

Decomposition:
- Package hpram_arb_pkg: state enum, CMD_WR=1'b0, CMD_RD=1'b1, grant-id encoding (GNT_WR, GNT_RD).
- Sub-module rr_arb2: two-input round-robin arbiter with a last_grant register and an enable input (IDLE & iinit_calib).

Test Plan:
- iinit_calib=0, both requests high for 100 cycles -> no ack, no ocmd_en; calib rises -> ord_ack at the next cycle (read wins the tie).
- Single write at addr 0x00100, data 0..15 -> ocmd_en once at T1 with ocmd=0; owr_data=0..15 on T1..T16; owr_done at T16; obusy low after CMD_GAP.
- Single read at 0x2A000; memory returns 16 beats with 2-cycle bubbles -> ord_valid/ord_data mirror them one cycle later; ord_done with beat 16.
- Both requests held continuously -> grants alternate R,W,R,W; gap between transaction end and next ack = CMD_GAP+1 cycles.
- Read with memory returning only 5 beats -> 5 ord_valid, ord_done at T1+255, oerr_timeout=1 and stays set; next write proceeds normally.
- irst asserted at beat 7 of a write -> next cycle all outputs 0, state IDLE; a pending read is granted after irst deasserts and calib is high.
